// File: rtl/uart_rx_buffer.sv
// UART receiver (8N1, LSB first) using x16 oversampling, feeding a
// show-ahead receive FIFO. Framing errors and overruns are reported as
// single-cycle pulses.
module uart_rx_buffer #(
  parameter int X16_DIV      = 163,
  parameter int FIFO_DEPTH   = 8,
  parameter int POINTER_SIZE = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rx,
  input  logic                    rd_Sig,
  output logic [7:0]              rx_Data,
  output logic                    sig_Empty,
  output logic                    sig_Full,
  output logic [POINTER_SIZE:0]   data_Count,
  output logic                    frame_Err,
  output logic                    overrun_Err
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_t;

  localparam logic [7:0]              TICK_LAST = 8'(X16_DIV - 1);
  localparam logic [POINTER_SIZE:0]   DEPTH_C   = (POINTER_SIZE + 1)'(FIFO_DEPTH);
  localparam logic [POINTER_SIZE-1:0] PTR_ONE   = POINTER_SIZE'(1);
  localparam logic [POINTER_SIZE:0]   CNT_ONE   = (POINTER_SIZE + 1)'(1);

  logic [7:0]              r_tick_cnt;
  logic                    w_tick;
  logic                    r_rx_meta;
  logic                    r_rx_sync;
  state_t                  r_state;
  logic [3:0]              r_sub;
  logic [2:0]              r_bit_idx;
  logic [7:0]              r_shift;
  logic [7:0]              r_mem [FIFO_DEPTH];
  logic [POINTER_SIZE-1:0] r_wr_ptr;
  logic [POINTER_SIZE-1:0] r_rd_ptr;
  logic [POINTER_SIZE:0]   r_count;
  logic                    w_stop_sample;
  logic                    w_push;
  logic                    w_frame_err;
  logic                    w_empty;
  logic                    w_full;
  logic                    w_wr;
  logic                    w_rd;

  assign w_tick = (r_tick_cnt == TICK_LAST);

  // Free-running x16 oversample tick generator
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick_cnt <= 8'd0;
    end else if (w_tick) begin
      r_tick_cnt <= 8'd0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 8'd1;
    end
  end

  // Two-flop synchronizer for the asynchronous serial line (idles high)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // Stop-bit decision is decoded combinationally so the push, the framing
  // error and any overrun all land in the stop-sample tick cycle itself.
  assign w_stop_sample = w_tick && (r_state == S_STOP) && (r_sub == 4'd15);
  assign w_push        = w_stop_sample && r_rx_sync;
  assign w_frame_err   = w_stop_sample && !r_rx_sync;

  // Receive FSM: start detect, start-center check, 8 data samples, stop check
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_sub     <= 4'd0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
    end else if (w_tick) begin
      case (r_state)
        S_IDLE: begin
          if (!r_rx_sync) begin
            r_state <= S_START;
            r_sub   <= 4'd0;
          end
        end
        S_START: begin
          if (r_sub == 4'd7) begin
            // A line that is high again at start-center was only a glitch
            if (!r_rx_sync) begin
              r_state   <= S_DATA;
              r_sub     <= 4'd0;
              r_bit_idx <= 3'd0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_sub <= r_sub + 4'd1;
          end
        end
        S_DATA: begin
          if (r_sub == 4'd15) begin
            r_shift <= {r_rx_sync, r_shift[7:1]};
            r_sub   <= 4'd0;
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_sub <= r_sub + 4'd1;
          end
        end
        S_STOP: begin
          if (r_sub == 4'd15) begin
            r_sub   <= 4'd0;
            // A low stop bit may be a break; wait for the line to recover
            r_state <= r_rx_sync ? S_IDLE : S_WAIT_IDLE;
          end else begin
            r_sub <= r_sub + 4'd1;
          end
        end
        S_WAIT_IDLE: begin
          if (r_rx_sync) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == DEPTH_C);
  assign w_rd    = rd_Sig && !w_empty;
  // When full, a push only fits if the head is popped in the same cycle
  assign w_wr    = w_push && (!w_full || rd_Sig);

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else if (w_wr) begin
      r_mem[r_wr_ptr] <= r_shift;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rx_Data     = r_mem[r_rd_ptr];
  assign sig_Empty   = w_empty;
  assign sig_Full    = w_full;
  assign data_Count  = r_count;
  assign frame_Err   = w_frame_err;
  assign overrun_Err = w_push && w_full && !rd_Sig;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Self-checking bench for uart_rx_buffer with a fast oversample divider.
module tb_uart_rx_buffer;

  localparam int X16     = 4;
  localparam int BIT_CLK = 16 * X16;
  // Ticks from start detection to stop-bit sample: 8 to start-center, then 9 x 16
  localparam int STOP_TICKS = 8 + 16 * 9;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       rd_Sig;
  logic [7:0] rx_Data;
  logic       sig_Empty;
  logic       sig_Full;
  logic [3:0] data_Count;
  logic       frame_Err;
  logic       overrun_Err;

  int n_checks = 0;
  int n_fail   = 0;
  int n_ferr   = 0;
  int n_ovr    = 0;
  int cyc      = 0;
  int ph       = 0;

  logic [7:0] exp_q[$];

  uart_rx_buffer #(
    .X16_DIV      (X16),
    .FIFO_DEPTH   (8),
    .POINTER_SIZE (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .rd_Sig      (rd_Sig),
    .rx_Data     (rx_Data),
    .sig_Empty   (sig_Empty),
    .sig_Full    (sig_Full),
    .data_Count  (data_Count),
    .frame_Err   (frame_Err),
    .overrun_Err (overrun_Err)
  );

  always #5 clk = ~clk;

  // Cycle counter and reference tick phase (free-running divider model)
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) ph <= 0;
    else       ph <= (ph == X16 - 1) ? 0 : ph + 1;
  end

  // Error pulse counters
  always @(negedge clk) begin
    if (frame_Err)   n_ferr <= n_ferr + 1;
    if (overrun_Err) n_ovr  <= n_ovr + 1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  // Called on a negedge; drives start, 8 data bits LSB first, stop
  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
    rx = 1'b1;
  endtask

  // Compare head against scoreboard, then pop for exactly one clock
  task automatic read_one(input string tag);
    logic [7:0] e;
    e = 8'h00;
    chk({tag, "_nonempty"}, {31'd0, sig_Empty}, 32'd0);
    chk({tag, "_q_avail"}, {31'd0, exp_q.size() != 0}, 32'd1);
    if (exp_q.size() != 0) e = exp_q.pop_front();
    chk({tag, "_data"}, {24'd0, rx_Data}, {24'd0, e});
    rd_Sig = 1'b1;
    @(negedge clk);
    rd_Sig = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_data"},  {24'd0, rx_Data},     32'h00);
    chk({tag, "_empty"}, {31'd0, sig_Empty},   32'd1);
    chk({tag, "_full"},  {31'd0, sig_Full},    32'd0);
    chk({tag, "_count"}, {28'd0, data_Count},  32'd0);
    chk({tag, "_ferr"},  {31'd0, frame_Err},   32'd0);
    chk({tag, "_ovr"},   {31'd0, overrun_Err}, 32'd0);
  endtask

  initial begin
    int f0;
    int o0;
    int p0;
    int ph0;
    int w;
    int dly;

    reset  = 1'b1;
    rx     = 1'b1;
    rd_Sig = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst");
    idle(20);

    // Single valid frame
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    idle(10);
    chk("a5_count", {28'd0, data_Count}, 32'd1);
    read_one("a5");
    #1;
    chk("a5_empty_after", {31'd0, sig_Empty}, 32'd1);
    chk("a5_count_after", {28'd0, data_Count}, 32'd0);
    idle(20);

    // Short low glitch on idle line
    f0 = n_ferr;
    rx = 1'b0;
    idle(16);
    rx = 1'b1;
    idle(200);
    chk("glitch_count", {28'd0, data_Count}, 32'd0);
    chk("glitch_ferr", n_ferr - f0, 32'd0);

    // Bad stop bit followed by a long break, then a good frame
    f0 = n_ferr;
    send_frame(8'h3C, 1'b0);
    rx = 1'b0;
    idle(500);
    rx = 1'b1;
    idle(BIT_CLK);
    chk("brk_ferr", n_ferr - f0, 32'd1);
    chk("brk_count", {28'd0, data_Count}, 32'd0);
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    idle(10);
    chk("brk_next_count", {28'd0, data_Count}, 32'd1);
    read_one("brk_next");
    idle(20);

    // Nine frames without reads: eighth fills, ninth overruns
    o0 = n_ovr;
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1);
      idle(4);
      if (i == 8) begin
        chk("fill_full", {31'd0, sig_Full}, 32'd1);
        chk("fill_count8", {28'd0, data_Count}, 32'd8);
        chk("fill_no_ovr_yet", n_ovr - o0, 32'd0);
      end
    end
    chk("ovr_pulse", n_ovr - o0, 32'd1);
    chk("ovr_count", {28'd0, data_Count}, 32'd8);
    for (int i = 1; i <= 8; i++) read_one("ovr_rd");
    #1;
    chk("ovr_drained", {31'd0, sig_Empty}, 32'd1);
    idle(20);

    // Full FIFO with a pop landing exactly on the push cycle
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(8'h20 + 8'(i));
      send_frame(8'h20 + 8'(i), 1'b1);
      idle(4);
    end
    chk("sim_full", {31'd0, sig_Full}, 32'd1);
    o0 = n_ovr;
    exp_q.push_back(8'h55);
    p0  = cyc;
    ph0 = ph;
    w   = (X16 - 1 - ((ph0 + 2) % X16) + X16) % X16;
    dly = 2 + w + X16 * STOP_TICKS;
    fork
      send_frame(8'h55, 1'b1);
      begin
        repeat (dly) @(negedge clk);
        read_one("sim_pop");
        #1;
        chk("sim_count_hold", {28'd0, data_Count}, 32'd8);
      end
    join
    idle(10);
    chk("sim_no_ovr", n_ovr - o0, 32'd0);
    chk("sim_count", {28'd0, data_Count}, 32'd8);
    for (int i = 0; i < 8; i++) read_one("sim_rd");
    #1;
    chk("sim_drained", {31'd0, sig_Empty}, 32'd1);
    idle(20);

    // Reset during bit 4 of a frame while the FIFO holds a byte
    send_frame(8'h77, 1'b1);
    idle(10);
    chk("pre_rst_count", {28'd0, data_Count}, 32'd1);
    f0 = n_ferr;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    rx = 1'b0;
    idle(BIT_CLK / 2);
    reset = 1'b1;
    rx    = 1'b1;
    idle(4);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_reset_outputs("midrst");
    idle(700);
    chk("midrst_no_push", {28'd0, data_Count}, 32'd0);
    chk("midrst_no_ferr", n_ferr - f0, 32'd0);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1);
    idle(10);
    chk("c3_count", {28'd0, data_Count}, 32'd1);
    read_one("c3");
    #1;
    chk("c3_empty_after", {31'd0, sig_Empty}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
